reg_bank_sb: RTL and testbench
==============================

# reg_bank_sb

Parametrised general-purpose register bank with a per-register pending-write scoreboard, same-cycle write-to-read bypass and a sequential bulk-clear engine. It sits between the decode/issue stage and the writeback stage of the core pipeline. Issue marks a destination pending, writeback writes the data and releases the register, and the read ports report both data and a busy flag so hazard logic can stall.

## Interface
Parameters:
- XLEN, 32: data width in bits.
- ADDR_W, 5: register address width; NREGS = 2**ADDR_W registers.
- ZERO_REG, 1: 1 = register 0 hardwired to zero (reads 0, writes and allocations ignored).
- BYPASS, 1: 1 = same-cycle writeback data forwarded to read ports.

Ports (clock and reset first):
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rs1_addr_i  in  ADDR_W  read port 1 address.
- rs2_addr_i  in  ADDR_W  read port 2 address.
- rs1_data_o  out  XLEN  read port 1 data (combinational).
- rs2_data_o  out  XLEN  read port 2 data (combinational).
- rs1_busy_o  out  1  read port 1 register has a pending write.
- rs2_busy_o  out  1  read port 2 register has a pending write.
- wr_en_i  in  1  writeback strobe.
- rd_addr_i  in  ADDR_W  writeback address.
- data_i  in  XLEN  writeback data.
- alloc_en_i  in  1  issue strobe: mark alloc_addr_i pending.
- alloc_addr_i  in  ADDR_W  register being allocated.
- clear_i  in  1  start bulk clear (one-cycle pulse sufficient).
- busy_o  out  1  clear engine active.

## Operation
- **Reset (rst_n low, asynchronous):**
  - All registers are 0 and all pending bits are 0.
  - The FSM is in IDLE, the clear counter is 0, and busy_o = 0.
  - Read outputs follow combinationally, so they are 0 with busy flags 0.
- **Read, per port:**
  - If ZERO_REG and addr == 0: data 0, busy 0.
  - Else, if BYPASS, the FSM is in IDLE, wr_en_i is high and rd_addr_i == addr: data = data_i and busy = 0.
  - Otherwise: data = regs[addr] and busy = pending[addr].
- **Write:** at the clock edge, regs[rd_addr_i] <= data_i when all of the following hold:
  - wr_en_i is high;
  - the FSM is in IDLE;
  - not (ZERO_REG and rd_addr_i == 0).
- A write to a register that is not pending is still performed.
- **Scoreboard, evaluated in IDLE only:**
  - wr_en_i clears pending[rd_addr_i].
  - alloc_en_i sets pending[alloc_addr_i].
  - Same address in the same cycle: the set wins, so the register ends pending (a new producer is in flight).
  - alloc to register 0 with ZERO_REG is ignored.
- **Clear FSM:** two states, IDLE and CLEAR.
  - IDLE -> CLEAR when clear_i is high. The counter loads 0.
  - In CLEAR, each cycle: regs[cnt] <= 0, pending[cnt] <= 0, then cnt increments.
  - CLEAR -> IDLE on the cycle that cnt == NREGS-1 is cleared. The counter wraps to 0.
  - In CLEAR, the following are ignored: wr_en_i, alloc_en_i, clear_i, and bypass.
  - Reads in CLEAR return the current array contents (partially cleared).
- busy_o = (state == CLEAR).

## Timing
- Read data and busy: zero-cycle combinational from address, and from wr_en_i/data_i when bypass is active.
- Write: visible through the array on the first read after the writing edge.
- Clear latency:
  - clear_i sampled at edge N: busy_o is high from edge N through edge N+NREGS, i.e. exactly NREGS cycles.
  - Register k is zero after edge N+1+k.
  - A write presented in the same cycle as clear_i (FSM still IDLE) is performed, then cleared by the sweep.
- Reset mid-clear: aborts immediately. IDLE, all registers 0, busy_o 0.
- Outputs have no registered stage, so there is no additional pipeline latency.

## Test plan
- **Reset:** hold rst_n low, drive rs1_addr_i=3, rs2_addr_i=31 -> both data 0, both busy 0, busy_o 0.
- **Write/read and x0:**
  - Write 0xDEADBEEF to r5, next cycle read rs1=r5 -> 0xDEADBEEF.
  - Write 0x12345678 to r0 -> rs2=r0 reads 0.
- **Bypass:** wr_en_i=1, rd_addr_i=7, data_i=0xA5A5A5A5 with rs1_addr_i=7 in the same cycle -> rs1_data_o=0xA5A5A5A5, rs1_busy_o=0 before the edge.
- **Scoreboard:**
  - alloc r9 -> rs1_busy_o=1 next cycle.
  - Writeback r9 with a simultaneous alloc r9 -> still busy.
  - Writeback r9 alone -> busy 0.
  - alloc r0 -> never busy.
- **Bulk clear:** fill r1..r31 with index values and allocate r4, then pulse clear_i.
  - busy_o is high for exactly 32 cycles.
  - A write to r2 and an alloc of r6 during CLEAR have no effect.
  - Afterwards all reads are 0 and not busy.
- **Reset mid-clear:** assert rst_n low 10 cycles into a clear -> busy_o 0 immediately, all registers read 0, the next clear_i starts a full 32-cycle sweep.

Source files
------------

// File: rtl/reg_bank_sb.sv
// General-purpose register bank with pending-write scoreboard, same-cycle
// writeback bypass to the read ports and a one-register-per-cycle bulk clear.
module reg_bank_sb #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              clear_i,
  output logic              busy_o
);

  localparam int NREGS = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;

  logic [XLEN-1:0]   regs_q [NREGS];
  logic [XLEN-1:0]   regs_d [NREGS];
  logic [NREGS-1:0]  pending_q;
  logic [NREGS-1:0]  pending_d;

  logic              idle;
  logic              wr_ok;
  logic              alloc_ok;

  logic [ADDR_W-1:0] raddr [2];
  logic [XLEN-1:0]   rdata [2];
  logic              rbusy [2];

  assign idle     = (state_q == IDLE);
  assign wr_ok    = wr_en_i    && !((ZERO_REG != 0) && (rd_addr_i    == '0));
  assign alloc_ok = alloc_en_i && !((ZERO_REG != 0) && (alloc_addr_i == '0));

  // Clear engine: walks cnt_q over every register, then drops back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (clear_i) begin
        state_q <= CLEAR;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end
    end else begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  // Alloc is applied after the writeback release so a same-address set wins
  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (idle) begin
      if (wr_ok) begin
        regs_d[rd_addr_i]    = data_i;
        pending_d[rd_addr_i] = 1'b0;
      end
      if (alloc_ok) begin
        pending_d[alloc_addr_i] = 1'b1;
      end
    end else begin
      regs_d[cnt_q]    = '0;
      pending_d[cnt_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign raddr[0] = rs1_addr_i;
  assign raddr[1] = rs2_addr_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = regs_q[raddr[p]];
      rbusy[p] = pending_q[raddr[p]];
      if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end else if ((BYPASS != 0) && idle && wr_en_i && (rd_addr_i == raddr[p])) begin
        rdata[p] = data_i;
        rbusy[p] = 1'b0;
      end
    end
  end

  assign rs1_data_o = rdata[0];
  assign rs2_data_o = rdata[1];
  assign rs1_busy_o = rbusy[0];
  assign rs2_busy_o = rbusy[1];
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_reg_bank_sb.sv
// Bench for reg_bank_sb: directed scenarios plus random traffic, all checked
// against an array-based model of the register bank.
module tb_reg_bank_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr_i, rs2_addr_i;
  logic [31:0] rs1_data_o, rs2_data_o;
  logic        rs1_busy_o, rs2_busy_o;
  logic        wr_en_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] data_i;
  logic        alloc_en_i;
  logic [4:0]  alloc_addr_i;
  logic        clear_i;
  logic        busy_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register contents, pending flags, and the index the
  // sweep clears next (-1 when no clear is running).
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  int          m_sweep;

  reg_bank_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .wr_en_i(wr_en_i), .rd_addr_i(rd_addr_i), .data_i(data_i),
    .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i),
    .clear_i(clear_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_sweep = -1;
  endtask

  function automatic logic [32:0] m_read(input logic [4:0] a);
    if (a == 0)                                   return 33'd0;
    if (m_sweep < 0 && wr_en_i && rd_addr_i == a) return {1'b0, data_i};
    return {m_pend[a], m_regs[a]};
  endfunction

  task automatic m_edge();
    if (m_sweep < 0) begin
      if (wr_en_i && rd_addr_i != 0) begin
        m_regs[rd_addr_i] = data_i;
        m_pend[rd_addr_i] = 1'b0;
      end
      if (alloc_en_i && alloc_addr_i != 0) m_pend[alloc_addr_i] = 1'b1;
      if (clear_i) m_sweep = 0;
    end else begin
      m_regs[m_sweep] = '0;
      m_pend[m_sweep] = 1'b0;
      m_sweep++;
      if (m_sweep == 32) m_sweep = -1;
    end
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en_i = 1'b0; alloc_en_i = 1'b0; clear_i = 1'b0;
  endtask

  task automatic check_reads(input string tag);
    logic [32:0] e1, e2;
    #1;
    e1 = m_read(rs1_addr_i);
    e2 = m_read(rs2_addr_i);
    chk({tag, ".rs1_data"}, rs1_data_o, e1[31:0]);
    chk({tag, ".rs1_busy"}, {31'd0, rs1_busy_o}, {31'd0, e1[32]});
    chk({tag, ".rs2_data"}, rs2_data_o, e2[31:0]);
    chk({tag, ".rs2_busy"}, {31'd0, rs2_busy_o}, {31'd0, e2[32]});
    chk({tag, ".busy_o"}, {31'd0, busy_o}, {31'd0, m_sweep >= 0});
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 32; a++) begin
      rs1_addr_i = 5'(a);
      rs2_addr_i = 5'(31 - a);
      #1;
      chk({tag, ".data"}, rs1_data_o | rs2_data_o, 32'd0);
      chk({tag, ".busy"}, {30'd0, rs1_busy_o, rs2_busy_o}, 32'd0);
    end
  endtask

  task automatic count_sweep(input string tag, input int cycles_before_stop, output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      if (i == 3) begin wr_en_i = 1'b1; rd_addr_i = 5'd2; data_i = 32'hFFFF_FFFF; end
      if (i == 4) begin alloc_en_i = 1'b1; alloc_addr_i = 5'd6; end
      if (i == 5) clear_i = 1'b1;
      rs1_addr_i = 5'd2;
      rs2_addr_i = 5'(i);
      check_reads(tag);
      if (!busy_o || n == cycles_before_stop) break;
      n++;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int nb;
    m_reset();
    rst_n = 1'b0;
    idle_inputs();
    rd_addr_i = '0; data_i = '0; alloc_addr_i = '0;
    rs1_addr_i = 5'd3; rs2_addr_i = 5'd31;
    check_reads("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    wr_en_i = 1'b1; rd_addr_i = 5'd5; data_i = 32'hDEAD_BEEF; rs1_addr_i = 5'd5;
    check_reads("wr_r5_bypass");
    tick();
    idle_inputs();
    check_reads("rd_r5");
    chk("rd_r5_const", rs1_data_o, 32'hDEAD_BEEF);

    wr_en_i = 1'b1; rd_addr_i = 5'd0; data_i = 32'h1234_5678; rs2_addr_i = 5'd0;
    check_reads("wr_r0");
    tick();
    idle_inputs();
    check_reads("rd_r0");
    chk("rd_r0_const", rs2_data_o, 32'd0);

    wr_en_i = 1'b1; rd_addr_i = 5'd7; data_i = 32'hA5A5_A5A5; rs1_addr_i = 5'd7;
    check_reads("bypass_r7");
    chk("bypass_r7_const", rs1_data_o, 32'hA5A5_A5A5);
    tick();
    idle_inputs();

    alloc_en_i = 1'b1; alloc_addr_i = 5'd9; rs1_addr_i = 5'd9;
    tick();
    idle_inputs();
    check_reads("alloc_r9");
    chk("alloc_r9_busy", {31'd0, rs1_busy_o}, 32'd1);
    wr_en_i = 1'b1; rd_addr_i = 5'd9; data_i = 32'h0000_0099;
    alloc_en_i = 1'b1; alloc_addr_i = 5'd9;
    tick();
    idle_inputs();
    check_reads("wb_alloc_r9");
    chk("wb_alloc_r9_busy", {31'd0, rs1_busy_o}, 32'd1);
    wr_en_i = 1'b1; rd_addr_i = 5'd9; data_i = 32'h0000_0123;
    tick();
    idle_inputs();
    check_reads("wb_r9");
    chk("wb_r9_busy", {31'd0, rs1_busy_o}, 32'd0);
    alloc_en_i = 1'b1; alloc_addr_i = 5'd0; rs2_addr_i = 5'd0;
    tick();
    idle_inputs();
    check_reads("alloc_r0");

    for (int i = 0; i < 400; i++) begin
      wr_en_i      = 1'($urandom_range(0, 1));
      rd_addr_i    = 5'($urandom_range(0, 31));
      data_i       = $urandom;
      alloc_en_i   = 1'($urandom_range(0, 1));
      alloc_addr_i = ($urandom_range(0, 3) == 0) ? rd_addr_i : 5'($urandom_range(0, 31));
      clear_i      = ($urandom_range(0, 59) == 0);
      rs1_addr_i   = ($urandom_range(0, 2) == 0) ? rd_addr_i : 5'($urandom_range(0, 31));
      rs2_addr_i   = 5'($urandom_range(0, 31));
      check_reads("random");
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 40 && m_sweep >= 0; i++) tick();

    for (int a = 1; a < 32; a++) begin
      wr_en_i = 1'b1; rd_addr_i = 5'(a); data_i = 32'(a);
      tick();
    end
    idle_inputs();
    alloc_en_i = 1'b1; alloc_addr_i = 5'd4;
    tick();
    idle_inputs();
    rs1_addr_i = 5'd4; rs2_addr_i = 5'd17;
    check_reads("filled");
    wr_en_i = 1'b1; rd_addr_i = 5'd3; data_i = 32'h3333_3333; clear_i = 1'b1;
    check_reads("clear_start");
    tick();
    count_sweep("sweep", 100, nb);
    chk("sweep_len", 32'(nb), 32'd32);
    check_all_zero("after_clear");

    wr_en_i = 1'b1; rd_addr_i = 5'd12; data_i = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    clear_i = 1'b1;
    tick();
    count_sweep("pre_abort", 10, nb);
    chk("pre_abort_busy", {31'd0, busy_o}, 32'd1);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("abort_busy_o", {31'd0, busy_o}, 32'd0);
    check_all_zero("abort");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b1;
    tick();
    count_sweep("resweep", 100, nb);
    chk("resweep_len", 32'(nb), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
